// File: rtl/voice_pkg.sv
// rtl/voice_pkg.sv - shared types and defaults for the voice allocator
package voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } alloc_state_e;

  localparam int NOTE_WIDTH         = 7;
  localparam int DEFAULT_NUM_VOICES = 4;
  localparam int DEFAULT_RATE_WIDTH = 24;
  localparam int DEFAULT_AGE_WIDTH  = 8;

endpackage

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - sequential-scan oscillator allocator with oldest-voice stealing
// Optional statistics counters are built only when VOICE_ALLOC_STATS_EN is defined.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int RATE_WIDTH = DEFAULT_RATE_WIDTH,
  parameter int AGE_WIDTH  = DEFAULT_AGE_WIDTH
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             note_valid_in,
  input  logic                             note_on_in,
  input  logic [NOTE_WIDTH-1:0]            note_in,
  input  logic [RATE_WIDTH-1:0]            rate_in,
  output logic                             ready_out,
  output logic [NUM_VOICES-1:0]            voice_on_out,
  output logic [NUM_VOICES*RATE_WIDTH-1:0] voice_rate_out,
  output logic                             alloc_valid_out,
  output logic [$clog2(NUM_VOICES)-1:0]    alloc_voice_out,
  output logic                             alloc_hit_out,
  output logic                             steal_out,
  output logic [15:0]                      steal_count_out,
  output logic [15:0]                      drop_count_out
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e          state_q;
  logic [IDX_W-1:0]      scan_idx_q;
  logic [NOTE_WIDTH-1:0] ev_note_q;
  logic                  ev_on_q;
  logic [RATE_WIDTH-1:0] ev_rate_q;

  logic [NOTE_WIDTH-1:0] voice_note_q [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  voice_age_q  [NUM_VOICES];

  logic                  match_found_q, free_found_q;
  logic [IDX_W-1:0]      match_idx_q, free_idx_q, old_idx_q;
  logic [AGE_WIDTH-1:0]  old_age_q;

  logic                  match_found_d, free_found_d;
  logic [IDX_W-1:0]      match_idx_d, free_idx_d, old_idx_d;
  logic [AGE_WIDTH-1:0]  old_age_d;
  logic [IDX_W-1:0]      pick_d;
  logic                  hit_d, steal_d;
  logic                  first_scan;

  // Running search state folded in with the voice under examination this cycle.
  always_comb begin
    first_scan    = (scan_idx_q == '0);
    match_found_d = match_found_q & ~first_scan;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q & ~first_scan;
    free_idx_d    = free_idx_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    pick_d        = '0;
    hit_d         = 1'b0;
    steal_d       = 1'b0;

    if (voice_on_out[scan_idx_q] && voice_note_q[scan_idx_q] == ev_note_q && !match_found_d) begin
      match_found_d = 1'b1;
      match_idx_d   = scan_idx_q;
    end
    if (!voice_on_out[scan_idx_q] && !free_found_d) begin
      free_found_d = 1'b1;
      free_idx_d   = scan_idx_q;
    end
    if (first_scan || voice_age_q[scan_idx_q] > old_age_q) begin
      old_idx_d = scan_idx_q;
      old_age_d = voice_age_q[scan_idx_q];
    end

    if (ev_on_q) begin
      hit_d = 1'b1;
      if (match_found_d) begin
        pick_d = match_idx_d;
      end else if (free_found_d) begin
        pick_d = free_idx_d;
      end else begin
        pick_d  = old_idx_d;
        steal_d = 1'b1;
      end
    end else begin
      hit_d  = match_found_d;
      pick_d = match_found_d ? match_idx_d : '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      ready_out       <= 1'b0;
      scan_idx_q      <= '0;
      ev_note_q       <= '0;
      ev_on_q         <= 1'b0;
      ev_rate_q       <= '0;
      match_found_q   <= 1'b0;
      match_idx_q     <= '0;
      free_found_q    <= 1'b0;
      free_idx_q      <= '0;
      old_idx_q       <= '0;
      old_age_q       <= '0;
      voice_on_out    <= '0;
      voice_rate_out  <= '0;
      alloc_valid_out <= 1'b0;
      alloc_voice_out <= '0;
      alloc_hit_out   <= 1'b0;
      steal_out       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_note_q[i] <= '0;
        voice_age_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_out <= 1'b1;
          if (note_valid_in && ready_out) begin
            ev_note_q  <= note_in;
            ev_on_q    <= note_on_in;
            ev_rate_q  <= rate_in;
            scan_idx_q <= '0;
            ready_out  <= 1'b0;
            state_q    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          match_found_q <= match_found_d;
          match_idx_q   <= match_idx_d;
          free_found_q  <= free_found_d;
          free_idx_q    <= free_idx_d;
          old_idx_q     <= old_idx_d;
          old_age_q     <= old_age_d;
          scan_idx_q    <= scan_idx_q + IDX_W'(1);
          if (scan_idx_q == LAST_IDX) begin
            alloc_valid_out <= 1'b1;
            alloc_voice_out <= pick_d;
            alloc_hit_out   <= hit_d;
            steal_out       <= steal_d;
            state_q         <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          alloc_valid_out <= 1'b0;
          steal_out       <= 1'b0;
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (ev_on_q) begin
              if (IDX_W'(i) == alloc_voice_out) begin
                voice_on_out[i]                               <= 1'b1;
                voice_rate_out[i*RATE_WIDTH +: RATE_WIDTH]    <= ev_rate_q;
                voice_note_q[i]                               <= ev_note_q;
                voice_age_q[i]                                <= '0;
              end else if (voice_on_out[i] && voice_age_q[i] != '1) begin
                voice_age_q[i] <= voice_age_q[i] + 1'b1;
              end
            end else if (alloc_hit_out && IDX_W'(i) == alloc_voice_out) begin
              voice_on_out[i] <= 1'b0;
            end
          end
          ready_out <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          ready_out <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VOICE_ALLOC_STATS_EN
  logic [15:0] steal_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      steal_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (state_q == ST_COMMIT && steal_out && steal_cnt_q != '1)
        steal_cnt_q <= steal_cnt_q + 16'd1;
      if (note_valid_in && !ready_out && drop_cnt_q != '1)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign steal_count_out = steal_cnt_q;
  assign drop_count_out  = drop_cnt_q;
`else
  assign steal_count_out = '0;
  assign drop_count_out  = '0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized self-checking bench for voice_allocator
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int RW = 24;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              note_valid_in, note_on_in;
  logic [6:0]        note_in;
  logic [RW-1:0]     rate_in;
  logic              ready_out;
  logic [NV-1:0]     voice_on_out;
  logic [NV*RW-1:0]  voice_rate_out;
  logic              alloc_valid_out;
  logic [1:0]        alloc_voice_out;
  logic              alloc_hit_out, steal_out;
  logic [15:0]       steal_count_out, drop_count_out;

  voice_allocator #(.NUM_VOICES(NV), .RATE_WIDTH(RW), .AGE_WIDTH(8)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .note_valid_in(note_valid_in),
    .note_on_in(note_on_in), .note_in(note_in), .rate_in(rate_in),
    .ready_out(ready_out), .voice_on_out(voice_on_out), .voice_rate_out(voice_rate_out),
    .alloc_valid_out(alloc_valid_out), .alloc_voice_out(alloc_voice_out),
    .alloc_hit_out(alloc_hit_out), .steal_out(steal_out),
    .steal_count_out(steal_count_out), .drop_count_out(drop_count_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference voice table: plain arrays updated by the allocation rules.
  bit m_on   [NV];
  int m_note [NV];
  int m_age  [NV];
  int m_rate [NV];
  int m_steals, m_drops;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_on[i] = 0; m_note[i] = 0; m_age[i] = 0; m_rate[i] = 0;
    end
    m_steals = 0;
    m_drops  = 0;
  endtask

  function automatic logic [NV-1:0] model_on_vec();
    logic [NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = m_on[i];
    return v;
  endfunction

  function automatic logic [NV*RW-1:0] model_rate_vec();
    logic [NV*RW-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*RW +: RW] = RW'(m_rate[i]);
    return v;
  endfunction

  task automatic model_event(input bit on, input int n, input int r,
                             output int v, output bit hit, output bit st);
    v = -1; hit = 0; st = 0;
    for (int i = 0; i < NV; i++)
      if (v < 0 && m_on[i] && m_note[i] == n) v = i;
    if (on) begin
      hit = 1;
      for (int i = 0; i < NV; i++)
        if (v < 0 && !m_on[i]) v = i;
      if (v < 0) begin
        int best = -1;
        st = 1;
        for (int i = 0; i < NV; i++)
          if (m_age[i] > best) begin best = m_age[i]; v = i; end
        m_steals++;
      end
      for (int i = 0; i < NV; i++) begin
        if (i == v) begin
          m_on[i] = 1; m_note[i] = n; m_rate[i] = r; m_age[i] = 0;
        end else if (m_on[i] && m_age[i] < 255) begin
          m_age[i]++;
        end
      end
    end else begin
      if (v >= 0) begin
        hit = 1;
        m_on[v] = 0;
      end else begin
        v = 0;
      end
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef VOICE_ALLOC_STATS_EN
    check({tag, "_steal_cnt"}, steal_count_out, m_steals);
    check({tag, "_drop_cnt"}, drop_count_out, m_drops);
`else
    check({tag, "_steal_cnt"}, steal_count_out, 0);
    check({tag, "_drop_cnt"}, drop_count_out, 0);
`endif
  endtask

  task automatic send_event(input bit on, input int n, input int r, input bit poke,
                            output int ov, output bit ohit, output bit ost);
    int v, j;
    bit hit, st, got;
    j = 0;
    while (!ready_out && j < 30) begin @(posedge clk_in); #1; j++; end
    check("ready_before_event", ready_out, 1);
    note_valid_in = 1; note_on_in = on; note_in = 7'(n); rate_in = RW'(r);
    @(posedge clk_in); #1;
    note_valid_in = 0; note_on_in = 1'($urandom); note_in = 7'($urandom); rate_in = RW'($urandom);
    model_event(on, n, r, v, hit, st);
    check("ready_low_after_accept", ready_out, 0);
    j = 0; got = 0;
    while (!got && j < 30) begin
      note_valid_in = poke && (j == 1);
      @(posedge clk_in); #1;
      if (note_valid_in) m_drops++;
      note_valid_in = 0;
      j++;
      got = alloc_valid_out;
    end
    check("alloc_latency", j + 1, NV + 1);
    ov = alloc_voice_out; ohit = alloc_hit_out; ost = steal_out;
    check("alloc_voice", alloc_voice_out, v);
    check("alloc_hit", alloc_hit_out, hit);
    check("steal", steal_out, st);
    @(posedge clk_in); #1;
    check("alloc_valid_one_cycle", alloc_valid_out, 0);
    check("steal_one_cycle", steal_out, 0);
    check("ready_after_commit", ready_out, 1);
    check("voice_on", voice_on_out, model_on_vec());
    check("voice_rate", voice_rate_out, model_rate_vec());
    check_stats("event");
  endtask

  int  ov;
  bit  ohit, ost;

  initial begin
    rst_n_in = 0; note_valid_in = 0; note_on_in = 0; note_in = '0; rate_in = '0;
    model_reset();
    #2;
    check("reset_ready", ready_out, 0);
    check("reset_voice_on", voice_on_out, 0);
    check("reset_rate", voice_rate_out, 0);
    check("reset_alloc_valid", alloc_valid_out, 0);
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1;
    @(posedge clk_in); #1;
    check("ready_after_reset", ready_out, 1);
    check_stats("reset");

    send_event(1, 60, 2000, 0, ov, ohit, ost);
    check("first_on_voice0", ov, 0);
    check("first_on_mask", voice_on_out, 4'b0001);
    check("first_on_rate0", voice_rate_out[RW-1:0], 2000);
    send_event(1, 62, 2100, 0, ov, ohit, ost);
    send_event(1, 64, 2200, 1, ov, ohit, ost);
    send_event(1, 65, 2300, 0, ov, ohit, ost);
    send_event(1, 67, 2400, 0, ov, ohit, ost);
    check("steal_oldest_voice", ov, 0);
    check("steal_flag", ost, 1);
    check("steal_mask", voice_on_out, 4'b1111);
    send_event(1, 62, 3000, 0, ov, ohit, ost);
    check("retrigger_voice", ov, 1);
    check("retrigger_no_steal", ost, 0);
    send_event(0, 70, 0, 0, ov, ohit, ost);
    check("off_unheld_hit", ohit, 0);
    check("off_unheld_mask", voice_on_out, 4'b1111);
    send_event(0, 62, 0, 0, ov, ohit, ost);
    check("off_62_voice", ov, 1);
    check("off_62_mask", voice_on_out, 4'b1101);

    // Reset in the middle of a scan discards the event and clears everything at once.
    note_valid_in = 1; note_on_in = 1; note_in = 7'd50; rate_in = 24'd99;
    @(posedge clk_in); #1;
    note_valid_in = 0;
    @(posedge clk_in); #1;
    rst_n_in = 0;
    #2;
    check("async_rst_ready", ready_out, 0);
    check("async_rst_on", voice_on_out, 0);
    check("async_rst_rate", voice_rate_out, 0);
    check("async_rst_valid", alloc_valid_out, 0);
    check("async_rst_steal", steal_out, 0);
    model_reset();
    check_stats("async_rst");
    @(posedge clk_in); #3;
    rst_n_in = 1;
    @(posedge clk_in); #1;
    check("ready_one_clk_after_release", ready_out, 1);
    check("post_rst_on", voice_on_out, 0);

    for (int k = 0; k < 60; k++) begin
      bit on;
      on = ($urandom_range(0, 2) != 0);
      send_event(on, $urandom_range(60, 67), int'($urandom_range(0, 24'hffffff)),
                 ($urandom_range(0, 5) == 0), ov, ohit, ost);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
